// File: rtl/matrix_delay_line.sv
// Valid-tagged, stallable matrix delay line with a runtime-selectable delay of 0..MAX_DELAY cycles.
// A delay change drains the line before it takes effect, so in-flight matrices are never corrupted.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_RUN   | normal operation, cfg_delay matches the requested delay
//   ST_DRAIN | delay change pending; input blocked until occupancy reaches 0
module matrix_delay_line #(
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 1,
    parameter int ROWS          = 12,
    parameter int COLS          = 12,
    parameter int DATA_WIDTH    = 64,
    parameter int DW_SEL        = $clog2(MAX_DELAY + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [DW_SEL-1:0]                        delay_sel,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                                     stall,
    input  logic                                     flush,
    output logic                                     out_valid,
    output logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] data_out,
    output logic [DW_SEL-1:0]                        cfg_delay,
    output logic                                     cfg_busy,
    output logic [DW_SEL-1:0]                        occupancy
);

    typedef logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_t;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]           state;
    logic [MAX_DELAY-1:0] stage_valid;
    mat_t                 stage_data [MAX_DELAY];

    logic [DW_SEL-1:0] sel_clamped;
    logic              bypass;
    logic              accept;
    logic              emit;
    logic              acc_line;
    logic              emit_line;
    logic              tap_valid;
    mat_t              tap_data;

    always_comb begin
        sel_clamped = (delay_sel > DW_SEL'(MAX_DELAY)) ? DW_SEL'(MAX_DELAY) : delay_sel;
        cfg_busy    = (sel_clamped != cfg_delay);
        bypass      = (cfg_delay == '0);
        in_ready    = rst_n & ~stall & ~flush & ~cfg_busy;
        accept      = in_valid & in_ready;
    end

    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (cfg_delay == DW_SEL'(i + 1)) begin
                tap_valid = stage_valid[i];
                tap_data  = stage_data[i];
            end
        end
    end

    always_comb begin
        if (!rst_n) begin
            out_valid = 1'b0;
            data_out  = '0;
        end else if (bypass) begin
            out_valid = accept;
            data_out  = data_in;
        end else begin
            out_valid = tap_valid;
            data_out  = tap_data;
        end
        emit      = out_valid & ~stall;
        acc_line  = accept & ~bypass;
        emit_line = emit & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_data[i] <= '0;
            end
            occupancy <= '0;
            cfg_delay <= DW_SEL'(DEFAULT_DELAY);
            state     <= ST_RUN;
        end else begin
            if (flush) begin
                stage_valid <= '0;
                occupancy   <= '0;
            end else if (!stall) begin
                stage_valid[0] <= acc_line;
                stage_data[0]  <= data_in;
                // Valid bits are dropped past the tap so a later delay increase never sees stale matrices.
                for (int i = 1; i < MAX_DELAY; i++) begin
                    stage_valid[i] <= stage_valid[i-1] & (DW_SEL'(i) < cfg_delay);
                    stage_data[i]  <= stage_data[i-1];
                end
                occupancy <= occupancy + DW_SEL'(acc_line) - DW_SEL'(emit_line);
            end

            case (state)
                ST_RUN: begin
                    if (cfg_busy) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!cfg_busy) begin
                        state <= ST_RUN;
                    end else if ((occupancy == '0) || flush) begin
                        cfg_delay <= sel_clamped;
                        state     <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_delay_line.sv
// Directed bench for matrix_delay_line: latency, stall, delay change, bypass, flush, clamp, reset.
module tb_matrix_delay_line;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [3:0]                delay_sel = 4'd3;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [1:0][1:0][15:0]     data_in = '0;
    logic                      stall = 1'b0;
    logic                      flush = 1'b0;
    logic                      out_valid;
    logic [1:0][1:0][15:0]     data_out;
    logic [3:0]                cfg_delay;
    logic                      cfg_busy;
    logic [3:0]                occupancy;

    int n_total = 0;
    int n_bad   = 0;

    int occ_e  [4]  = '{1, 1, 1, 0};
    int st_s   [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int st_in  [12] = '{0, 1, 2, 3, 4, 4, 4, 5, -1, -1, -1, -1};
    int st_out [12] = '{-1, -1, -1, 0, 1, 1, 1, 2, 3, 4, 5, -1};

    localparam logic [63:0] MAT_A = 64'h0004_0003_0002_0001;

    matrix_delay_line #(
        .MAX_DELAY(8), .DEFAULT_DELAY(3), .ROWS(2), .COLS(2), .DATA_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .delay_sel(delay_sel),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .data_out(data_out),
        .cfg_delay(cfg_delay), .cfg_busy(cfg_busy), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mat(input int i);
        return 64'h1000_2000_3000_4000 + 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: inputs change just after the falling edge, checks follow #1 later.
    task automatic drive(input logic r, input logic [3:0] sel, input logic v,
                         input logic [63:0] d, input logic s, input logic f);
        @(negedge clk);
        rst_n = r; delay_sel = sel; in_valid = v; data_in = d; stall = s; flush = f;
        #1;
    endtask

    initial begin
        // reset
        drive(0, 3, 1, MAT_A, 0, 0);
        check("rst_ready", in_ready, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_dout", data_out, 0);
        drive(0, 3, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        check("rst_cfg", cfg_delay, 3);
        check("rst_occ", occupancy, 0);
        check("rst_busy", cfg_busy, 0);

        // basic latency 3
        drive(1, 3, 1, MAT_A, 0, 0);
        check("b_ready", in_ready, 1);
        check("b_ovalid0", out_valid, 0);
        for (int c = 1; c <= 4; c++) begin
            drive(1, 3, 0, 0, 0, 0);
            check("b_occ", occupancy, 64'(occ_e[c-1]));
            check("b_ovalid", out_valid, (c == 3));
            if (c == 3) check("b_data", data_out, MAT_A);
        end

        // streaming with stall at cycles 4-5
        for (int c = 0; c < 12; c++) begin
            drive(1, 3, (st_in[c] >= 0), (st_in[c] >= 0) ? mat(st_in[c]) : 64'h0,
                  st_s[c] != 0, 0);
            check("s_ready", in_ready, (st_s[c] == 0));
            check("s_ovalid", out_valid, (st_out[c] >= 0));
            if (st_out[c] >= 0) check("s_data", data_out, mat(st_out[c]));
            if (c == 5) check("s_occ_stall", occupancy, 3);
        end

        // delay change 3 -> 5 with two matrices in flight
        drive(1, 3, 1, mat(10), 0, 0);
        drive(1, 3, 1, mat(11), 0, 0);
        drive(1, 5, 1, mat(12), 0, 0);
        check("d_busy", cfg_busy, 1);
        check("d_ready2", in_ready, 0);
        drive(1, 5, 1, mat(12), 0, 0);
        check("d_ready3", in_ready, 0);
        check("d_ov3", out_valid, 1);
        check("d_data3", data_out, mat(10));
        check("d_occ3", occupancy, 2);
        drive(1, 5, 1, mat(12), 0, 0);
        check("d_ov4", out_valid, 1);
        check("d_data4", data_out, mat(11));
        check("d_occ4", occupancy, 1);
        drive(1, 5, 1, mat(12), 0, 0);
        check("d_occ5", occupancy, 0);
        check("d_cfg_old", cfg_delay, 3);
        check("d_ready5", in_ready, 0);
        drive(1, 5, 1, mat(12), 0, 0);
        check("d_cfg_new", cfg_delay, 5);
        check("d_ready6", in_ready, 1);
        check("d_ov6", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 5, 0, 0, 0, 0);
            check("d_ov_gap", out_valid, 0);
        end
        drive(1, 5, 0, 0, 0, 0);
        check("d_ov11", out_valid, 1);
        check("d_data11", data_out, mat(12));
        drive(1, 5, 0, 0, 0, 0);
        check("d_ov12", out_valid, 0);

        // bypass
        drive(1, 0, 0, 0, 0, 0);
        check("p_busy", cfg_busy, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, mat(20), 0, 0);
        check("p_cfg", cfg_delay, 0);
        check("p_ov", out_valid, 1);
        check("p_data", data_out, mat(20));
        drive(1, 0, 1, mat(21), 0, 0);
        check("p_data2", data_out, mat(21));
        check("p_occ", occupancy, 0);
        drive(1, 0, 0, mat(22), 0, 0);
        check("p_ov_idle", out_valid, 0);
        check("p_occ2", occupancy, 0);

        // flush at occupancy 3
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 3, 1, mat(30), 0, 0);
        check("f_cfg", cfg_delay, 3);
        check("f_ready", in_ready, 1);
        drive(1, 3, 1, mat(31), 0, 0);
        drive(1, 3, 1, mat(32), 0, 0);
        drive(1, 3, 1, mat(33), 0, 1);
        check("f_occ_pre", occupancy, 3);
        check("f_ready_fl", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 0, 0, 0, 0);
            check("f_occ", occupancy, 0);
            check("f_ov", out_valid, 0);
        end

        // clamp 15 -> 8
        drive(1, 15, 0, 0, 0, 0);
        check("c_busy", cfg_busy, 1);
        drive(1, 15, 0, 0, 0, 0);
        drive(1, 15, 0, 0, 0, 0);
        check("c_cfg", cfg_delay, 8);
        check("c_busy_done", cfg_busy, 0);

        // stall and flush together: flush wins
        drive(1, 15, 1, mat(40), 0, 0);
        check("g_ready", in_ready, 1);
        drive(1, 15, 0, 0, 1, 1);
        check("g_ready_sf", in_ready, 0);
        drive(1, 15, 0, 0, 0, 0);
        check("g_occ", occupancy, 0);
        for (int k = 0; k < 9; k++) begin
            drive(1, 15, 0, 0, 0, 0);
            check("g_ov", out_valid, 0);
        end

        // reset mid-stream
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 3, 1, mat(50), 0, 0);
        check("r_cfg", cfg_delay, 3);
        drive(1, 3, 1, mat(51), 0, 0);
        drive(0, 3, 0, 0, 0, 0);
        check("r_occ_pre", occupancy, 2);
        check("r_ov_rst", out_valid, 0);
        check("r_ready_rst", in_ready, 0);
        drive(1, 3, 0, 0, 0, 0);
        check("r_cfg_post", cfg_delay, 3);
        check("r_occ_post", occupancy, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 3, 0, 0, 0, 0);
            check("r_ov_post", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
